// File: rtl/clock_period_meter.sv
// clock_period_meter: measures an asynchronous clock-like input in HCLK cycles,
// summed over a window of 2^PRE input periods. The result is period = N * 2^PRE.
module clock_period_meter #(
   parameter int unsigned WIDTH = 24
) (
   input  logic             HCLK,
   input  logic             n_RST,
   input  logic             clk_in,
   input  logic             enable,
   input  logic [2:0]       PRE,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] period,
   output logic             period_valid,
   output logic             overflow,
   output logic             busy
);

   localparam int unsigned ECNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_MEASURE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic              r_s1;
   logic              r_s2;
   logic              r_s3;
   logic              w_edge;

   logic [WIDTH-1:0]  r_cnt;
   logic [WIDTH-1:0]  w_cnt_nxt;
   logic [ECNT_W-1:0] r_ecnt;
   logic [ECNT_W-1:0] w_ecnt_nxt;
   logic [2:0]        r_pre_q;
   logic [2:0]        w_pre_q_nxt;
   logic [WIDTH-1:0]  r_period;
   logic [WIDTH-1:0]  w_period_nxt;
   logic              r_valid;
   logic              w_valid_nxt;
   logic              r_ovf;
   logic              w_ovf_nxt;
   logic              r_busy;

   logic              w_win_done;
   logic              w_cnt_max;
   logic              w_ovf_evt;

   // The closing edge of a window is the edge that brings ecnt past 2^pre_q.
   assign w_edge     = r_s2 & ~r_s3;
   assign w_win_done = w_edge && (r_ecnt == (ECNT_W'(1) << r_pre_q));
   assign w_cnt_max  = &r_cnt;
   // Any MEASURE cycle other than a window close needs an increment.
   assign w_ovf_evt  = enable && (r_state == ST_MEASURE) && !w_win_done && w_cnt_max;

   // Three-flop synchronizer for the asynchronous measured input.
   always_ff @(posedge HCLK or negedge n_RST) begin
      if (!n_RST) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= clk_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   // State register.
   always_ff @(posedge HCLK or negedge n_RST) begin
      if (!n_RST) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic; enable low always forces IDLE.
   always_comb begin
      w_state_nxt = r_state;
      if (!enable) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:    w_state_nxt = ST_ARM;
            ST_ARM:     if (w_edge) w_state_nxt = ST_MEASURE;
            ST_MEASURE: if (w_ovf_evt) w_state_nxt = ST_ARM;
            default:    w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Datapath next values: counters, result capture and sticky overflow.
   always_comb begin
      w_cnt_nxt    = r_cnt;
      w_ecnt_nxt   = r_ecnt;
      w_pre_q_nxt  = r_pre_q;
      w_period_nxt = r_period;
      w_valid_nxt  = 1'b0;
      w_ovf_nxt    = clr_ovf ? 1'b0 : r_ovf;
      if (!enable) begin
         w_cnt_nxt  = '0;
         w_ecnt_nxt = '0;
      end else begin
         case (r_state)
            ST_ARM: begin
               if (w_edge) begin
                  w_cnt_nxt   = WIDTH'(1);
                  w_ecnt_nxt  = ECNT_W'(1);
                  w_pre_q_nxt = PRE;
               end
            end
            ST_MEASURE: begin
               if (w_win_done) begin
                  // Closing edge doubles as the opening edge of the next window.
                  w_period_nxt = r_cnt;
                  w_valid_nxt  = 1'b1;
                  w_cnt_nxt    = WIDTH'(1);
                  w_ecnt_nxt   = ECNT_W'(1);
                  w_pre_q_nxt  = PRE;
               end else if (w_cnt_max) begin
                  // Abort the window; overflow set takes priority over clear.
                  w_ovf_nxt  = 1'b1;
                  w_cnt_nxt  = '0;
                  w_ecnt_nxt = '0;
               end else begin
                  w_cnt_nxt = r_cnt + WIDTH'(1);
                  if (w_edge) w_ecnt_nxt = r_ecnt + ECNT_W'(1);
               end
            end
            default: begin
               w_cnt_nxt  = '0;
               w_ecnt_nxt = '0;
            end
         endcase
      end
   end

   // Datapath and output registers.
   always_ff @(posedge HCLK or negedge n_RST) begin
      if (!n_RST) begin
         r_cnt    <= '0;
         r_ecnt   <= '0;
         r_pre_q  <= '0;
         r_period <= '0;
         r_valid  <= 1'b0;
         r_ovf    <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_cnt    <= w_cnt_nxt;
         r_ecnt   <= w_ecnt_nxt;
         r_pre_q  <= w_pre_q_nxt;
         r_period <= w_period_nxt;
         r_valid  <= w_valid_nxt;
         r_ovf    <= w_ovf_nxt;
         r_busy   <= (w_state_nxt == ST_MEASURE);
      end
   end

   assign period       = r_period;
   assign period_valid = r_valid;
   assign overflow     = r_ovf;
   assign busy         = r_busy;

endmodule

// File: tb/tb_clock_period_meter.sv
// tb_clock_period_meter: randomized and directed checks of clock_period_meter
// against a window-level model (period = N * 2^PRE, PRE taken at the opening rise).
module tb_clock_period_meter;

   logic        HCLK;
   logic        n_RST;
   logic        clk_in;
   logic        enable;
   logic [2:0]  PRE;
   logic        clr_ovf;
   logic [23:0] period;
   logic        period_valid;
   logic        overflow;
   logic        busy;

   logic        en8;
   logic [2:0]  pre8;
   logic        clr8;
   logic [7:0]  period8;
   logic        valid8;
   logic        overflow8;
   logic        busy8;

   int checks = 0;
   int failures = 0;

   int cyc = 0;
   int gen_n = 0;
   int gen_ph = 0;
   int rises = 0;
   int last_rise_cyc = 0;
   int pre_at_rise [0:1023];
   logic [23:0] exp_period = '0;

   clock_period_meter #(.WIDTH(24)) u_dut (
      .HCLK(HCLK), .n_RST(n_RST), .clk_in(clk_in), .enable(enable), .PRE(PRE),
      .clr_ovf(clr_ovf), .period(period), .period_valid(period_valid),
      .overflow(overflow), .busy(busy)
   );

   clock_period_meter #(.WIDTH(8)) u_dut8 (
      .HCLK(HCLK), .n_RST(n_RST), .clk_in(clk_in), .enable(en8), .PRE(pre8),
      .clr_ovf(clr8), .period(period8), .period_valid(valid8),
      .overflow(overflow8), .busy(busy8)
   );

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   always @(posedge HCLK) cyc <= cyc + 1;

   // clk_in generator: period gen_n cycles, high for gen_n/2; logs each rise.
   initial begin
      clk_in = 1'b0;
      forever begin
         @(posedge HCLK);
         #1;
         if (gen_n == 0) begin
            clk_in = 1'b0;
            gen_ph = 0;
         end else begin
            if (gen_ph == 0) begin
               rises = rises + 1;
               pre_at_rise[rises & 1023] = int'(PRE);
               last_rise_cyc = cyc;
            end
            clk_in = (gen_ph < gen_n / 2);
            gen_ph = (gen_ph + 1) % gen_n;
         end
      end
   end

   task automatic run_windows(input int pre, input int n, input int nwin,
                              input int chg_pre, input string tag);
      int got;
      int budget;
      int last_valid;
      int open_idx;
      int wpre;
      int maxp;
      logic [23:0] want;
      gen_n = 0;
      enable = 1'b0;
      repeat (3) @(negedge HCLK);
      PRE = 3'(pre);
      enable = 1'b1;
      repeat (3) @(negedge HCLK);
      rises = 0;
      gen_n = n;
      maxp = (chg_pre > pre) ? chg_pre : pre;
      budget = n * ((1 << maxp) * (nwin + 1) + 2) + 50;
      got = 0;
      open_idx = 1;
      last_valid = 0;
      while (got < nwin && budget > 0) begin
         @(negedge HCLK);
         budget--;
         if (period_valid === 1'b1) begin
            wpre = pre_at_rise[open_idx & 1023];
            want = 24'(n << wpre);
            checks++;
            if (period !== want) begin
               failures++;
               $display("FAIL %s period: got %0d want %0d", tag, period, want);
            end
            checks++;
            if (rises != open_idx + (1 << wpre)) begin
               failures++;
               $display("FAIL %s rises_at_valid: got %0d want %0d", tag, rises, open_idx + (1 << wpre));
            end
            checks++;
            if (cyc - last_rise_cyc != 3) begin
               failures++;
               $display("FAIL %s valid_latency: got %0d want 3", tag, cyc - last_rise_cyc);
            end
            checks++;
            if (busy !== 1'b1) begin
               failures++;
               $display("FAIL %s busy_at_valid: got %b want 1", tag, busy);
            end
            if (got > 0) begin
               checks++;
               if (cyc - last_valid != (n << wpre)) begin
                  failures++;
                  $display("FAIL %s valid_spacing: got %0d want %0d", tag, cyc - last_valid, n << wpre);
               end
            end
            open_idx = open_idx + (1 << wpre);
            exp_period = want;
            last_valid = cyc;
            got++;
            if (got == 1 && chg_pre >= 0) PRE = 3'(chg_pre);
         end else begin
            checks++;
            if (period !== exp_period) begin
               failures++;
               $display("FAIL %s period_hold: got %0d want %0d", tag, period, exp_period);
            end
         end
      end
      checks++;
      if (got != nwin) begin
         failures++;
         $display("FAIL %s valid_count: got %0d want %0d", tag, got, nwin);
      end
   endtask

   task automatic test_reset();
      n_RST = 1'b0;
      repeat (2) @(negedge HCLK);
      checks++;
      if ({period, period_valid, overflow, busy} !== 27'd0) begin
         failures++;
         $display("FAIL reset_outputs: got %h want 0", {period, period_valid, overflow, busy});
      end
      checks++;
      if ({period8, valid8, overflow8, busy8} !== 11'd0) begin
         failures++;
         $display("FAIL reset_outputs8: got %h want 0", {period8, valid8, overflow8, busy8});
      end
      n_RST = 1'b1;
      repeat (2) @(negedge HCLK);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_busy: got %b want 0", busy);
      end
   endtask

   task automatic test_random();
      int p;
      int n;
      for (int i = 0; i < 4; i++) begin
         p = int'($urandom_range(0, 3));
         n = int'($urandom_range(4, 20));
         run_windows(p, n, 3, -1, "random");
      end
   endtask

   task automatic test_enable_drop();
      run_windows(1, 8, 1, -1, "pre_drop");
      repeat (5) @(negedge HCLK);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL drop_busy_before: got %b want 1", busy);
      end
      enable = 1'b0;
      @(negedge HCLK);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL drop_busy_after: got %b want 0", busy);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge HCLK);
         checks++;
         if (period_valid !== 1'b0 || period !== exp_period) begin
            failures++;
            $display("FAIL drop_quiet: valid %b period %0d want valid 0 period %0d", period_valid, period, exp_period);
         end
      end
      run_windows(2, 6, 2, -1, "after_drop");
   endtask

   task automatic test_overflow();
      int budget;
      bit saw_valid;
      gen_n = 0;
      en8 = 1'b0;
      pre8 = 3'd0;
      clr8 = 1'b0;
      repeat (3) @(negedge HCLK);
      en8 = 1'b1;
      repeat (3) @(negedge HCLK);
      rises = 0;
      gen_n = 300;
      saw_valid = 1'b0;
      budget = 400;
      while (overflow8 !== 1'b1 && budget > 0) begin
         @(negedge HCLK);
         budget--;
         if (valid8 === 1'b1) saw_valid = 1'b1;
      end
      checks++;
      if (overflow8 !== 1'b1) begin
         failures++;
         $display("FAIL ovf_set: got %b want 1", overflow8);
      end
      checks++;
      if (cyc - last_rise_cyc != 258) begin
         failures++;
         $display("FAIL ovf_latency: got %0d want 258", cyc - last_rise_cyc);
      end
      checks++;
      if (saw_valid || period8 !== 8'd0) begin
         failures++;
         $display("FAIL ovf_no_result: valid_seen %b period %0d want 0 0", saw_valid, period8);
      end
      gen_n = 0;
      repeat (4) @(negedge HCLK);
      checks++;
      if (overflow8 !== 1'b1) begin
         failures++;
         $display("FAIL ovf_sticky: got %b want 1", overflow8);
      end
      clr8 = 1'b1;
      @(negedge HCLK);
      clr8 = 1'b0;
      checks++;
      if (overflow8 !== 1'b0) begin
         failures++;
         $display("FAIL ovf_clear: got %b want 0", overflow8);
      end
      rises = 0;
      gen_n = 300;
      budget = 10;
      while (rises == 0 && budget > 0) begin
         @(negedge HCLK);
         budget--;
      end
      budget = 300;
      while (cyc != last_rise_cyc + 257 && budget > 0) begin
         @(negedge HCLK);
         budget--;
      end
      checks++;
      if (budget == 0 || overflow8 !== 1'b0) begin
         failures++;
         $display("FAIL ovf_pre_collide: budget %0d overflow %b want overflow 0", budget, overflow8);
      end
      clr8 = 1'b1;
      @(negedge HCLK);
      clr8 = 1'b0;
      checks++;
      if (overflow8 !== 1'b1) begin
         failures++;
         $display("FAIL ovf_set_wins: got %b want 1", overflow8);
      end
      checks++;
      if (period8 !== 8'd0) begin
         failures++;
         $display("FAIL ovf_period_hold: got %0d want 0", period8);
      end
      gen_n = 0;
      repeat (3) @(negedge HCLK);
   endtask

   task automatic test_async_reset();
      run_windows(1, 7, 1, -1, "pre_rst");
      repeat (3) @(negedge HCLK);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL rst_busy_before: got %b want 1", busy);
      end
      #3 n_RST = 1'b0;
      #1;
      checks++;
      if ({period, period_valid, overflow, busy} !== 27'd0) begin
         failures++;
         $display("FAIL async_reset: got %h want 0", {period, period_valid, overflow, busy});
      end
      checks++;
      if (overflow8 !== 1'b0) begin
         failures++;
         $display("FAIL async_reset8: overflow got %b want 0", overflow8);
      end
      gen_n = 0;
      @(negedge HCLK);
      n_RST = 1'b1;
      exp_period = '0;
      run_windows(0, 5, 2, -1, "post_rst");
   endtask

   initial begin
      n_RST = 1'b0;
      enable = 1'b0;
      PRE = 3'd0;
      clr_ovf = 1'b0;
      en8 = 1'b0;
      pre8 = 3'd0;
      clr8 = 1'b0;
      test_reset();
      run_windows(0, 10, 3, -1, "pre0_n10");
      run_windows(3, 6, 2, -1, "pre3_n6");
      test_random();
      run_windows(0, 10, 3, 2, "pre_change");
      test_enable_drop();
      test_overflow();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
